// File: rtl/adler32_pkg.sv
// Shared constants, FSM state type and the modulo-65521 reduction used by the
// streaming Adler-32 engine.
package adler32_pkg;

   localparam int          ADLER_MOD  = 65521;
   localparam logic [31:0] ADLER_INIT = 32'h00000001;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // Exact x mod 65521 for any 32-bit x. Because 2^16 mod 65521 = 15, the value
   // is folded twice (hi*15 + lo). After the second fold the result is below
   // 2*65521, so a single conditional subtract finishes the reduction.
   function automatic logic [15:0] mod65521(input logic [31:0] x);
      logic [20:0] fold1;
      logic [16:0] fold2;
      fold1 = 21'(x[31:16]) * 21'd15 + 21'(x[15:0]);
      fold2 = 17'(fold1[20:16]) * 17'd15 + 17'(fold1[15:0]);
      if (fold2 >= 17'(ADLER_MOD)) begin
         fold2 = fold2 - 17'(ADLER_MOD);
      end
      return fold2[15:0];
   endfunction

endpackage

// File: rtl/adler32_lane_fold.sv
// Combinational per-beat Adler-32 update. It folds the first k lanes of one
// beat into the running sums A and B. Lanes k and above do not affect the
// result.
module adler32_lane_fold
   import adler32_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic [15:0]        a_in,
   input  logic [15:0]        b_in,
   input  logic [8*LANES-1:0] in_data,
   input  logic [3:0]         k,
   output logic [15:0]        a_out,
   output logic [15:0]        b_out
);

   logic [31:0] sum_a;
   logic [31:0] sum_b;

   // A' = A + sum(d_i), B' = B + k*A + sum((k-i)*d_i), over i < k; both are
   // reduced exactly.
   always_comb begin
      sum_a = 32'(a_in);
      sum_b = 32'(b_in) + 32'(k) * 32'(a_in);
      for (int i = 0; i < LANES; i++) begin
         if (k > 4'(i)) begin
            sum_a = sum_a + 32'(in_data[8*i +: 8]);
            sum_b = sum_b + (32'(k) - 32'(i)) * 32'(in_data[8*i +: 8]);
         end
      end
      a_out = mod65521(sum_a);
      b_out = mod65521(sum_b);
   end

endmodule

// File: rtl/adler32_stream.sv
// Streaming Adler-32 engine. It takes a job descriptor, then accepts LANES
// bytes per beat until the job length has been consumed. The engine then
// holds {B,A} until the consumer takes it.
module adler32_stream
   import adler32_pkg::*;
#(
   parameter int LANES = 4,
   parameter int LEN_W = 32
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               abort,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [31:0]        cfg_seed,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_checksum,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [15:0]        a_q, a_d;
   logic [15:0]        b_q, b_d;
   logic [31:0]        checksum_q, checksum_d;

   logic [3:0]         k;
   logic [15:0]        fold_a, fold_b;
   logic [15:0]        seed_a, seed_b;

   assign k = (remaining_q >= LEN_W'(LANES)) ? 4'(LANES) : remaining_q[3:0];

   assign seed_a = mod65521(32'(cfg_seed[15:0]));
   assign seed_b = mod65521(32'(cfg_seed[31:16]));

   adler32_lane_fold #(
      .LANES (LANES)
   ) u_fold (
      .a_in    (a_q),
      .b_in    (b_q),
      .in_data (in_data),
      .k       (k),
      .a_out   (fold_a),
      .b_out   (fold_b)
   );

   // Next-state logic: abort wins over every handshake. The result register only
   // changes when a job completes.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      a_d         = a_q;
      b_d         = b_q;
      checksum_d  = checksum_q;
      if (abort) begin
         state_d     = IDLE;
         remaining_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  a_d         = seed_a;
                  b_d         = seed_b;
                  remaining_d = cfg_len;
                  if (cfg_len == '0) begin
                     state_d    = DONE;
                     checksum_d = {seed_b, seed_a};
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (in_valid) begin
                  a_d         = fold_a;
                  b_d         = fold_b;
                  remaining_d = remaining_q - LEN_W'(k);
                  if (remaining_d == '0) begin
                     state_d    = DONE;
                     checksum_d = {fold_b, fold_a};
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, asynchronously cleared to the idle state.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         a_q         <= ADLER_INIT[15:0];
         b_q         <= ADLER_INIT[31:16];
         checksum_q  <= ADLER_INIT;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         a_q         <= a_d;
         b_q         <= b_d;
         checksum_q  <= checksum_d;
      end
   end

   assign cfg_ready    = (state_q == IDLE);
   assign in_ready     = (state_q == RUN);
   assign out_valid    = (state_q == DONE);
   assign busy         = (state_q == RUN) || (state_q == DONE);
   assign out_checksum = checksum_q;

endmodule
